// File: rtl/fifo_pkg.sv
// Shared defaults for the FIFO controller and its 16x8 dual-port RAM.
package fifo_pkg;
    localparam int FIFO_WIDTH     = 8;
    localparam int FIFO_DEPTH     = 16;
    localparam int FIFO_ADDR_W    = 4;
    localparam int FIFO_AF_MARGIN = 2;
endpackage

// File: rtl/fifo_ptr.sv
// ADDR_W+1-bit wrapping pointer; the extra MSB separates full from empty.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            enb,
    output logic [ADDR_W:0] ptr
);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            ptr <= '0;
        end else if (enb) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_ram.sv
// Simple dual-port RAM with a registered read port (1-cycle read latency).
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH  = FIFO_WIDTH,
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic              clock,
    input  logic              wr_enb,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              re_enb,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_enb) begin
            mem[wr_addr] <= wr_data;
        end
        if (re_enb) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller driving an external dual-port RAM; registered count and flags,
// sticky overflow/underflow, read data returned one cycle after an accepted pop.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int WIDTH     = FIFO_WIDTH,
    parameter int DEPTH     = FIFO_DEPTH,
    parameter int ADDR_W    = FIFO_ADDR_W,
    parameter int AF_MARGIN = FIFO_AF_MARGIN
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              push,
    input  logic [WIDTH-1:0]  din,
    input  logic              pop,
    output logic [WIDTH-1:0]  dout,
    output logic              dout_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    output logic              ram_wr_enb,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [WIDTH-1:0]  ram_wr_data,
    output logic              ram_re_enb,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [WIDTH-1:0]  ram_rd_data
);

    localparam logic [ADDR_W:0] AF_LEVEL = (ADDR_W+1)'(DEPTH - AF_MARGIN);

    logic            push_acc;
    logic            pop_acc;
    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic [ADDR_W:0] wr_nxt;
    logic [ADDR_W:0] rd_nxt;
    logic [ADDR_W:0] count_nxt;
    logic            vld_p1;

    // resetn gating keeps both RAM enables low during a reset cycle
    assign push_acc = resetn & push & ~full;
    assign pop_acc  = resetn & pop & ~empty;

    assign ram_wr_enb  = push_acc;
    assign ram_wr_addr = wr_ptr[ADDR_W-1:0];
    assign ram_wr_data = din;
    assign ram_re_enb  = pop_acc;
    assign ram_rd_addr = rd_ptr[ADDR_W-1:0];

    fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
        .clock  (clock),
        .resetn (resetn),
        .enb    (push_acc),
        .ptr    (wr_ptr)
    );

    fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
        .clock  (clock),
        .resetn (resetn),
        .enb    (pop_acc),
        .ptr    (rd_ptr)
    );

    assign wr_nxt = wr_ptr + (ADDR_W+1)'(push_acc);
    assign rd_nxt = rd_ptr + (ADDR_W+1)'(pop_acc);

    always_comb begin
        count_nxt = count;
        case ({push_acc, pop_acc})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // p1: flags are derived from next-state pointers so they match count
    always_ff @(posedge clock) begin
        if (!resetn) begin
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            vld_p1      <= 1'b0;
        end else begin
            count       <= count_nxt;
            empty       <= (wr_nxt == rd_nxt);
            full        <= (wr_nxt[ADDR_W] != rd_nxt[ADDR_W]) &&
                           (wr_nxt[ADDR_W-1:0] == rd_nxt[ADDR_W-1:0]);
            almost_full <= (count_nxt >= AF_LEVEL);
            if (push && full) begin
                overflow <= 1'b1;
            end
            if (pop && empty) begin
                underflow <= 1'b1;
            end
            vld_p1      <= pop_acc;
        end
    end

    assign dout_valid = vld_p1;
    assign dout       = ram_rd_data;

endmodule
